// File: rtl/clod_pim_row_sequencer_if.sv
// Command and address-handshake bundle between the PIM controller/array and the row sequencer.
interface clod_pim_row_sequencer_if #(
  parameter int addr_bits = 10
);
  logic                 i_start;
  logic [addr_bits-1:0] i_base;
  logic [addr_bits:0]   i_len;
  logic                 i_abort;
  logic [addr_bits-1:0] o_addr;
  logic                 o_addr_valid;
  logic                 i_addr_ready;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_cmd_err;
  logic [addr_bits:0]   o_beat_count;

  modport master (
    output i_start, i_base, i_len, i_abort, i_addr_ready,
    input  o_addr, o_addr_valid, o_busy, o_done, o_cmd_err, o_beat_count
  );

  modport slave (
    input  i_start, i_base, i_len, i_abort, i_addr_ready,
    output o_addr, o_addr_valid, o_busy, o_done, o_cmd_err, o_beat_count
  );
endinterface

// File: rtl/clod_pim_row_sequencer.sv
// Row address sequencer: turns a (base, length) command into a valid/ready stream of
// row addresses that wrap at num_rows-1, with done/error pulses and a beat counter.
module clod_pim_row_sequencer #(
  parameter int num_rows  = 1024,
  parameter int addr_bits = 10
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  clod_pim_row_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [addr_bits-1:0] last_row_c = addr_bits'(num_rows - 1);
  localparam logic [addr_bits:0]   max_len_c  = (addr_bits + 1)'(num_rows);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [addr_bits-1:0] addr_r;
  logic [addr_bits-1:0] addr_nxt_s;
  logic [addr_bits-1:0] addr_inc_s;
  logic [addr_bits:0]   remaining_r;
  logic [addr_bits:0]   remaining_nxt_s;
  logic [addr_bits:0]   beat_r;
  logic [addr_bits:0]   beat_nxt_s;
  logic                 valid_r;
  logic                 valid_nxt_s;
  logic                 busy_r;
  logic                 busy_nxt_s;
  logic                 done_r;
  logic                 done_nxt_s;
  logic                 err_r;
  logic                 err_nxt_s;
  logic                 handshake_s;
  logic                 cmd_ok_s;

  assign handshake_s = valid_r & bus.i_addr_ready;
  assign cmd_ok_s    = ({1'b0, bus.i_base} < max_len_c) && (bus.i_len <= max_len_c);
  assign addr_inc_s  = (addr_r == last_row_c) ? {addr_bits{1'b0}} : addr_r + addr_bits'(1);

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; abort wins over a same-cycle final handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_start && cmd_ok_s) begin
          state_nxt_s = (bus.i_len != {(addr_bits + 1){1'b0}}) ? ST_ISSUE : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.i_abort) begin
          state_nxt_s = ST_IDLE;
        end else if (handshake_s && (remaining_r == (addr_bits + 1)'(1))) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    addr_nxt_s      = addr_r;
    remaining_nxt_s = remaining_r;
    beat_nxt_s      = beat_r;
    valid_nxt_s     = (state_nxt_s == ST_ISSUE);
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
    done_nxt_s      = (state_nxt_s == ST_DONE);
    err_nxt_s       = bus.i_start && ((state_r != ST_IDLE) || !cmd_ok_s);
    case (state_r)
      ST_IDLE: begin
        if (bus.i_start && cmd_ok_s) begin
          addr_nxt_s      = bus.i_base;
          remaining_nxt_s = bus.i_len;
          beat_nxt_s      = {(addr_bits + 1){1'b0}};
        end else begin
          addr_nxt_s      = addr_r;
        end
      end
      ST_ISSUE: begin
        if (handshake_s) begin
          addr_nxt_s      = addr_inc_s;
          remaining_nxt_s = remaining_r - (addr_bits + 1)'(1);
          beat_nxt_s      = beat_r + (addr_bits + 1)'(1);
        end else begin
          addr_nxt_s      = addr_r;
        end
      end
      default: begin
        addr_nxt_s = addr_r;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_r      <= {addr_bits{1'b0}};
      remaining_r <= {(addr_bits + 1){1'b0}};
      beat_r      <= {(addr_bits + 1){1'b0}};
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      addr_r      <= addr_nxt_s;
      remaining_r <= remaining_nxt_s;
      beat_r      <= beat_nxt_s;
      valid_r     <= valid_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign bus.o_addr       = addr_r;
  assign bus.o_addr_valid = valid_r;
  assign bus.o_busy       = busy_r;
  assign bus.o_done       = done_r;
  assign bus.o_cmd_err    = err_r;
  assign bus.o_beat_count = beat_r;

endmodule

// File: tb/tb_clod_pim_row_sequencer.sv
// Scoreboard bench: stimulus pushes expected addresses/done/error events, a negedge monitor pops and compares.
module tb_clod_pim_row_sequencer;

  localparam int NR = 1024;
  localparam int AB = 11;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  clod_pim_row_sequencer_if #(.addr_bits(AB)) bus ();

  clod_pim_row_sequencer #(.num_rows(NR), .addr_bits(AB)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int exp_addr_q[$];
  int exp_done_q[$];
  int exp_err_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every handshake, done pulse and error pulse against the scoreboard.
  initial begin
    bit prev_stall = 1'b0;
    int prev_addr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && bus.o_addr_valid) check("addr_stable", int'(bus.o_addr), prev_addr);
        prev_stall = bus.o_addr_valid && !bus.i_addr_ready;
        prev_addr  = int'(bus.o_addr);
        if (bus.o_addr_valid && bus.i_addr_ready) begin
          if (exp_addr_q.size() == 0) check("unexpected_beat", int'(bus.o_addr), -1);
          else check("addr", int'(bus.o_addr), exp_addr_q.pop_front());
        end
        if (bus.o_done) begin
          if (exp_done_q.size() == 0) check("unexpected_done", int'(bus.o_beat_count), -1);
          else check("done_beat_count", int'(bus.o_beat_count), exp_done_q.pop_front());
        end
        if (bus.o_cmd_err) begin
          check("unexpected_cmd_err", int'(exp_err_cnt > 0), 1);
          if (exp_err_cnt > 0) exp_err_cnt--;
        end
      end
    end
  end

  // mode: 0 ready high, 1 random ready, 2 fixed ready pattern, 3 ready high + start while busy,
  // 4 ready high + abort together with the start strobe.
  task automatic run_cmd(input int base, input int len, input int mode);
    int n;
    bit pattern[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < len; i++) exp_addr_q.push_back((base + i) % NR);
    exp_done_q.push_back(len);
    bus.i_base = AB'(base);
    bus.i_len = (AB + 1)'(len);
    bus.i_start = 1'b1;
    bus.i_abort = (mode == 4);
    bus.i_addr_ready = 1'b1;
    step();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    check("busy_after_start", int'(bus.o_busy), 1);
    check("valid_after_start", int'(bus.o_addr_valid), int'(len != 0));
    check("beat_count_cleared", int'(bus.o_beat_count), 0);
    n = 0;
    while (bus.o_busy && n < 5000) begin
      if (mode == 1) bus.i_addr_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2) bus.i_addr_ready = (n < 6) ? pattern[n] : 1'b1;
      else bus.i_addr_ready = 1'b1;
      if (mode == 3 && n == 1) begin
        bus.i_start = 1'b1;
        bus.i_base = AB'(3);
        bus.i_len = (AB + 1)'(2);
        exp_err_cnt++;
      end else begin
        bus.i_start = 1'b0;
      end
      step();
      n++;
    end
    bus.i_start = 1'b0;
    check("cmd_completes", int'(bus.o_busy), 0);
    if (mode == 0 || mode == 3 || mode == 4) check("cycles", n, len + 1);
    check("final_beat_count", int'(bus.o_beat_count), len);
    check("final_valid", int'(bus.o_addr_valid), 0);
    check("addr_q_drained", exp_addr_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);
    step();
    check("err_drained", exp_err_cnt, 0);
  endtask

  task automatic err_cmd(input int base, input int len);
    bus.i_base = AB'(base);
    bus.i_len = (AB + 1)'(len);
    bus.i_start = 1'b1;
    exp_err_cnt++;
    step();
    bus.i_start = 1'b0;
    check("err_stays_idle", int'(bus.o_busy), 0);
    check("err_no_valid", int'(bus.o_addr_valid), 0);
    step();
    check("err_pulse_seen", exp_err_cnt, 0);
    check("err_cleared", int'(bus.o_cmd_err), 0);
  endtask

  initial begin
    int base;
    int len;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_base = '0;
    bus.i_len = '0;
    bus.i_abort = 1'b0;
    bus.i_addr_ready = 1'b0;
    step();
    step();
    check("rst_addr", int'(bus.o_addr), 0);
    check("rst_valid", int'(bus.o_addr_valid), 0);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_done", int'(bus.o_done), 0);
    check("rst_err", int'(bus.o_cmd_err), 0);
    check("rst_beats", int'(bus.o_beat_count), 0);
    rst = 1'b0;
    step();

    // Reset in the middle of a command: three beats, then everything clears, no done.
    bus.i_addr_ready = 1'b1;
    bus.i_base = AB'(5);
    bus.i_len = (AB + 1)'(8);
    bus.i_start = 1'b1;
    for (int i = 0; i < 3; i++) exp_addr_q.push_back(5 + i);
    step();
    bus.i_start = 1'b0;
    step();
    step();
    step();
    check("pre_reset_beats", int'(bus.o_beat_count), 3);
    rst = 1'b1;
    #1;
    check("midrst_addr", int'(bus.o_addr), 0);
    check("midrst_valid", int'(bus.o_addr_valid), 0);
    check("midrst_busy", int'(bus.o_busy), 0);
    check("midrst_beats", int'(bus.o_beat_count), 0);
    check("midrst_beats_seen", exp_addr_q.size(), 0);
    step();
    rst = 1'b0;
    step();
    run_cmd(0, 2, 0);

    run_cmd(1022, 4, 0);
    run_cmd(10, 3, 2);
    err_cmd(1024, 3);
    err_cmd(0, 1025);
    run_cmd(0, 5, 3);

    // Abort together with the third handshake.
    bus.i_addr_ready = 1'b1;
    bus.i_base = AB'(100);
    bus.i_len = (AB + 1)'(10);
    bus.i_start = 1'b1;
    for (int i = 0; i < 3; i++) exp_addr_q.push_back(100 + i);
    step();
    bus.i_start = 1'b0;
    step();
    step();
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
    check("abort_valid", int'(bus.o_addr_valid), 0);
    check("abort_busy", int'(bus.o_busy), 0);
    check("abort_beats", int'(bus.o_beat_count), 3);
    check("abort_done", int'(bus.o_done), 0);
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
    step();
    check("idle_abort_beats", int'(bus.o_beat_count), 3);
    check("idle_abort_busy", int'(bus.o_busy), 0);
    check("abort_addr_drained", exp_addr_q.size(), 0);

    run_cmd(7, 0, 0);
    run_cmd(20, 3, 4);
    run_cmd(517, NR, 0);
    run_cmd(0, NR, 1);

    for (int k = 0; k < 25; k++) begin
      base = $urandom_range(0, NR - 1);
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      run_cmd(base, len, 1);
    end

    check("end_addr_q", exp_addr_q.size(), 0);
    check("end_done_q", exp_done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clod_pim_row_sequencer.md
Name: clod_pim_row_sequencer

Overview:
Command-driven address generator feeding the PIM array row/column decoder. It accepts a (base, length) command and issues one address per valid/ready handshake. Addresses wrap modulo num_rows, using the same wrap-at-(num_rows-1) rule as the PIM up counter. It reports beat progress, completion and command errors to the PIM controller.

Parameters:
num_rows, 1024, number of addressable rows; legal addresses are 0..num_rows-1.
addr_bits, 10, width of address ports; must satisfy 2**addr_bits >= num_rows.

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_start  input  1  command strobe, sampled every cycle
i_base  input  addr_bits  first address of the command
i_len  input  addr_bits+1  number of addresses to issue (0..num_rows)
i_abort  input  1  cancel the current command
o_addr  output  addr_bits  current address to the array
o_addr_valid  output  1  o_addr is valid
i_addr_ready  input  1  array accepts o_addr this cycle
o_busy  output  1  command in progress (ISSUE or DONE state)
o_done  output  1  one-cycle pulse: command completed normally
o_cmd_err  output  1  one-cycle pulse: command rejected
o_beat_count  output  addr_bits+1  handshakes completed for current/last command

Behaviour:
- Reset (async, any state): state=IDLE, o_addr=0, o_addr_valid=0, o_busy=0, o_done=0, o_cmd_err=0, o_beat_count=0. Reset mid-command discards the command; no done pulse.
- Handshake: a beat completes on a rising edge with o_addr_valid && i_addr_ready. o_addr is held stable while valid && !ready. Valid never drops without a handshake, except on abort or reset.
- State machine (registered outputs):
  - IDLE: i_start with i_base < num_rows and i_len <= num_rows accepts the command.
    - Load addr=i_base, remaining=i_len, o_beat_count=0.
    - If i_len != 0, go to ISSUE; o_addr_valid=1 from the next cycle (1-cycle start latency).
    - If i_len == 0, go to DONE directly.
    - Illegal command (i_base >= num_rows or i_len > num_rows): o_cmd_err pulses next cycle, stay in IDLE, nothing else changes.
  - ISSUE: on each handshake:
    - o_beat_count += 1, remaining -= 1.
    - addr = (addr == num_rows-1) ? 0 : addr+1.
    - If remaining was 1, clear o_addr_valid and go to DONE.
  - DONE: o_done=1 for exactly this one cycle, then go to IDLE. o_busy drops in the same edge o_done drops.
- i_start while o_busy=1 is ignored; o_cmd_err pulses next cycle.
- i_abort in ISSUE goes to IDLE next edge and clears o_addr_valid; no o_done.
  - If a handshake occurs in the same cycle as abort, that beat is counted in o_beat_count.
  - i_abort in IDLE or DONE has no effect; a DONE in progress still pulses o_done.
- i_start and i_abort in the same cycle while in IDLE: the start is accepted (abort is ignored in IDLE).
- o_beat_count holds its final value after DONE/abort until the next accepted command.
- o_addr holds its last value when o_addr_valid=0.
- Full-range command (i_len=num_rows) visits every row exactly once, wrapping once unless i_base=0.
- Throughput: one address per cycle with i_addr_ready tied high.

Test Plan:
1. Reset mid-ISSUE: base=5, len=8, assert i_reset after 3 beats → all outputs 0 immediately, no o_done; next command base=0, len=2 → beats 0,1, then o_done.
2. Wrap, ready=1: num_rows=1024, base=1022, len=4 → o_addr 1022,1023,0,1 on consecutive cycles; o_done 1 cycle after last beat; o_beat_count=4.
3. Backpressure: base=10, len=3, i_addr_ready toggled 1,0,0,1,0,1 → o_addr holds 11 across stalls; sequence 10,11,12; o_done once.
4. Errors: base=1024 → o_cmd_err pulse, stays IDLE; len=1025 → o_cmd_err; start during ISSUE of base=0, len=5 → o_cmd_err, running command unaffected (5 beats, o_done).
5. Abort with simultaneous handshake on beat 3 of base=100, len=10 → o_beat_count=3, o_addr_valid=0 next cycle, no o_done, o_busy=0.
6. len=0 at base=7 → no o_addr_valid; o_busy high for one cycle with o_done pulse; o_beat_count=0.
